reg_file: RTL and testbench
===========================

# reg_file

Architectural register file with per-register rename tags for the out-of-order RISC-V core. It sits directly downstream of the reorder buffer: it consumes the ROB's in-order commit stream and writes committed results. It also serves the dispatcher, which reads operand values or ROB aliases each cycle and renames the destination register of every newly issued instruction. On branch mispredict rollback it discards all pending renames so that the committed state becomes authoritative again.

## Interface
- XLEN, 32, data width.
- ROB_ID_W, 4, ROB alias width; alias 0 means "no pending producer", valid aliases are 1..2^ROB_ID_W-1.
- NREG, 32, architectural register count; index width is 5.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  mispredict flush from the ROB.
- commit_en  in  1  ROB commit write valid.
- commit_rd  in  5  destination register of the committing entry.
- commit_val  in  XLEN  committed result.
- commit_alias  in  ROB_ID_W  ROB id of the committing entry.
- rename_en  in  1  dispatcher issues an instruction with a destination.
- rename_rd  in  5  destination register to rename.
- rename_alias  in  ROB_ID_W  ROB id allocated to that instruction.
- rs1_idx, rs2_idx  in  5 each  operand queries.
- rs1_busy, rs2_busy  out  1 each  operand has a pending producer.
- rs1_alias, rs2_alias  out  ROB_ID_W each  producer ROB id; 0 when not busy.
- rs1_val, rs2_val  out  XLEN each  register value; meaningful only when not busy.

## Operation
- State: value[NREG] of XLEN bits and alias[NREG] of ROB_ID_W bits.
- busy(r) = (alias[r] != 0). Register x0 reads value 0, is never busy, and ignores every write and rename.
- Commit (commit_en, commit_rd != 0): value[commit_rd] <= commit_val. alias[commit_rd] <= 0 only if alias[commit_rd] == commit_alias; otherwise a younger instruction still owns the register, so the alias is kept.
- Rename (rename_en, rename_rd != 0): alias[rename_rd] <= rename_alias.
- Commit and rename to the same rd in the same cycle: the value is written and the alias becomes rename_alias. Rename wins over the alias clear.
- Rollback: clear every alias to 0 in one cycle. Values are preserved. A commit in the same cycle still writes its value. A rename in the same cycle is dropped.
- Priority order: rst > !rdy (hold) > rollback > rename > commit-alias-clear.
- Reads are combinational from registered state. A same-cycle rename never affects the reads, so an instruction with rs == rd sees the previous mapping.

## Timing
- Reset: all value = 0 and all alias = 0, so every busy = 0, alias = 0, val = 0 the cycle after rst.
- Commit write and rename are visible on read ports the cycle after the edge that samples them (1-cycle latency), except where the bypass below applies.
- Rollback takes effect at the sampling edge; the next cycle all operands read not busy.
- rdy low: no state changes; inputs on that cycle are lost. Upstream holds or re-presents them.

## Configuration
- REGFILE_BYPASS_EN defined: commit-to-read forwarding. If commit_en and commit_rd == rsX_idx != 0 and alias[rsX_idx] == commit_alias in the same cycle, then rsX_busy = 0, rsX_alias = 0, rsX_val = commit_val combinationally. This saves one dispatch stall cycle.
- Not defined: reads reflect only registered state; the operand appears ready one cycle after commit.

## Test plan
- Reset, then query rs1=5, rs2=0 -> busy 0/0, val 0/0, alias 0/0.
- Rename x5->alias 3; next cycle query rs1=5 -> busy 1, alias 3. Commit rd=5, alias 3, val 0xDEADBEEF; next cycle -> busy 0, val 0xDEADBEEF.
- Rename x7->2, then x7->6; commit rd=7, alias 2, val 0x11 -> val 0x11, still busy, alias 6. Commit alias 6, val 0x22 -> not busy, val 0x22.
- Same cycle: commit rd=9 alias 4 val 0x55 (x9 aliased 4) and rename x9->8 -> next cycle val 0x55, alias 8, busy 1.
- Rename x1->1, x2->2, x3->3; assert rollback with rename x4->5 -> next cycle x1..x4 all not busy, x4 alias 0, values unchanged.
- Rename and commit to x0 with value 0x99 -> x0 reads val 0, busy 0. With REGFILE_BYPASS_EN: x5 aliased 3, commit rd=5 alias 3 val 0x7 while querying rs1=5 -> same cycle busy 0, val 0x7; without the macro, busy 1 that cycle and val 0x7 the next.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: architectural register file with per-register ROB rename tags.
// Commits write values in order. Renames tag a destination with the ROB id
// of its pending producer. Rollback drops every pending tag at once.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle commit to the read
// ports. With the macro undefined, reads see only registered state.
module reg_file #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4,
  parameter int NREG     = 32,
  localparam int IDX_W   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                commit_en,
  input  logic [IDX_W-1:0]    commit_rd,
  input  logic [XLEN-1:0]     commit_val,
  input  logic [ROB_ID_W-1:0] commit_alias,
  input  logic                rename_en,
  input  logic [IDX_W-1:0]    rename_rd,
  input  logic [ROB_ID_W-1:0] rename_alias,
  input  logic [IDX_W-1:0]    rs1_idx,
  input  logic [IDX_W-1:0]    rs2_idx,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs1_alias,
  output logic [ROB_ID_W-1:0] rs2_alias,
  output logic [XLEN-1:0]     rs1_val,
  output logic [XLEN-1:0]     rs2_val
);

  logic [NREG-1:0][XLEN-1:0]     value_q, value_d;
  logic [NREG-1:0][ROB_ID_W-1:0] alias_q, alias_d;

  // Next state: commit writes value and clears a matching tag; rollback
  // wipes all tags and drops the rename; otherwise rename overrides the clear.
  // x0 is never written, so it always reads zero and never busy.
  always_comb begin
    value_d = value_q;
    alias_d = alias_q;
    if (commit_en && commit_rd != '0) begin
      value_d[commit_rd] = commit_val;
      if (alias_q[commit_rd] == commit_alias) alias_d[commit_rd] = '0;
    end
    if (rollback) begin
      alias_d = '0;
    end else if (rename_en && rename_rd != '0) begin
      alias_d[rename_rd] = rename_alias;
    end
  end

  // State update: sync reset, rdy low holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      alias_q <= '0;
    end else if (rdy) begin
      value_q <= value_d;
      alias_q <= alias_d;
    end
  end

  logic [1:0][IDX_W-1:0]    rs_idx;
  logic [1:0]               rs_busy;
  logic [1:0][ROB_ID_W-1:0] rs_alias;
  logic [1:0][XLEN-1:0]     rs_val;

  assign rs_idx = {rs2_idx, rs1_idx};

  // Operand reads from registered state; same-cycle renames are invisible.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_alias[p] = alias_q[rs_idx[p]];
      rs_val[p]   = value_q[rs_idx[p]];
`ifdef REGFILE_BYPASS_EN
      if (commit_en && rs_idx[p] != '0 && commit_rd == rs_idx[p] &&
          alias_q[rs_idx[p]] == commit_alias) begin
        rs_alias[p] = '0;
        rs_val[p]   = commit_val;
      end
`endif
      rs_busy[p] = (rs_alias[p] != '0);
    end
  end

  assign rs1_busy  = rs_busy[0];
  assign rs2_busy  = rs_busy[1];
  assign rs1_alias = rs_alias[0];
  assign rs2_alias = rs_alias[1];
  assign rs1_val   = rs_val[0];
  assign rs2_val   = rs_val[1];

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_alias;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_alias;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_alias, rs2_alias;
  logic [31:0] rs1_val, rs2_val;

  int checks   = 0;
  int failures = 0;

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_alias(commit_alias),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_alias(rename_alias),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_alias(rs1_alias), .rs2_alias(rs2_alias),
    .rs1_val(rs1_val), .rs2_val(rs2_val)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rollback  = 1'b0;
    commit_en = 1'b0; commit_rd = '0; commit_val = '0; commit_alias = '0;
    rename_en = 1'b0; rename_rd = '0; rename_alias = '0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] a);
    rename_en = 1'b1; rename_rd = rd; rename_alias = a;
    step();
    idle();
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] a, input logic [31:0] v);
    commit_en = 1'b1; commit_rd = rd; commit_alias = a; commit_val = v;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; idle();
    rs1_idx = 5'd5; rs2_idx = 5'd0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if ({rs1_busy, rs2_busy} !== 2'b00) begin
      failures++; $display("FAIL reset_busy got=%b exp=00", {rs1_busy, rs2_busy});
    end
    checks++;
    if (rs1_val !== 32'h0 || rs2_val !== 32'h0) begin
      failures++; $display("FAIL reset_val got=%h/%h exp=0/0", rs1_val, rs2_val);
    end
    checks++;
    if (rs1_alias !== 4'h0 || rs2_alias !== 4'h0) begin
      failures++; $display("FAIL reset_alias got=%h/%h exp=0/0", rs1_alias, rs2_alias);
    end
  endtask

  task automatic test_rename_commit();
    rename(5'd5, 4'd3);
    rs1_idx = 5'd5; #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd3) begin
      failures++; $display("FAIL rename_x5 got busy=%b alias=%0d exp busy=1 alias=3", rs1_busy, rs1_alias);
    end
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    checks++;
    if (rs1_busy !== 1'b0 || rs1_val !== 32'hDEADBEEF || rs1_alias !== 4'd0) begin
      failures++; $display("FAIL commit_x5 got busy=%b val=%h alias=%0d exp busy=0 val=deadbeef alias=0", rs1_busy, rs1_val, rs1_alias);
    end
  endtask

  task automatic test_younger_owner();
    rename(5'd7, 4'd2);
    rename(5'd7, 4'd6);
    rs2_idx = 5'd7;
    commit(5'd7, 4'd2, 32'h11);
    checks++;
    if (rs2_val !== 32'h11 || rs2_busy !== 1'b1 || rs2_alias !== 4'd6) begin
      failures++; $display("FAIL older_commit got val=%h busy=%b alias=%0d exp val=11 busy=1 alias=6", rs2_val, rs2_busy, rs2_alias);
    end
    commit(5'd7, 4'd6, 32'h22);
    checks++;
    if (rs2_val !== 32'h22 || rs2_busy !== 1'b0 || rs2_alias !== 4'd0) begin
      failures++; $display("FAIL owner_commit got val=%h busy=%b alias=%0d exp val=22 busy=0 alias=0", rs2_val, rs2_busy, rs2_alias);
    end
  endtask

  task automatic test_same_cycle();
    rename(5'd9, 4'd4);
    rs1_idx = 5'd9;
    commit_en = 1'b1; commit_rd = 5'd9; commit_alias = 4'd4; commit_val = 32'h55;
    rename_en = 1'b1; rename_rd = 5'd9; rename_alias = 4'd8;
    step(); idle();
    checks++;
    if (rs1_val !== 32'h55 || rs1_alias !== 4'd8 || rs1_busy !== 1'b1) begin
      failures++; $display("FAIL commit_rename_same got val=%h alias=%0d busy=%b exp val=55 alias=8 busy=1", rs1_val, rs1_alias, rs1_busy);
    end
  endtask

  task automatic test_rollback();
    rename(5'd1, 4'd1);
    rename(5'd2, 4'd2);
    rename(5'd3, 4'd3);
    rs1_idx = 5'd2; #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd2) begin
      failures++; $display("FAIL pre_rollback got busy=%b alias=%0d exp busy=1 alias=2", rs1_busy, rs1_alias);
    end
    // Rollback with a dropped rename and a commit whose value must still land.
    rollback  = 1'b1;
    rename_en = 1'b1; rename_rd = 5'd4; rename_alias = 4'd5;
    commit_en = 1'b1; commit_rd = 5'd3; commit_alias = 4'd1; commit_val = 32'h33;
    step(); idle();
    for (int r = 1; r <= 4; r++) begin
      rs1_idx = 5'(r); #1;
      checks++;
      if (rs1_busy !== 1'b0 || rs1_alias !== 4'd0) begin
        failures++; $display("FAIL rollback_x%0d got busy=%b alias=%0d exp busy=0 alias=0", r, rs1_busy, rs1_alias);
      end
    end
    rs1_idx = 5'd3; rs2_idx = 5'd5; #1;
    checks++;
    if (rs1_val !== 32'h33 || rs2_val !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rollback_vals got=%h/%h exp=33/deadbeef", rs1_val, rs2_val);
    end
  endtask

  task automatic test_x0();
    rename_en = 1'b1; rename_rd = 5'd0; rename_alias = 4'd7;
    commit_en = 1'b1; commit_rd = 5'd0; commit_alias = 4'd0; commit_val = 32'h99;
    step(); idle();
    rs2_idx = 5'd0; #1;
    checks++;
    if (rs2_val !== 32'h0 || rs2_busy !== 1'b0 || rs2_alias !== 4'd0) begin
      failures++; $display("FAIL x0 got val=%h busy=%b alias=%0d exp val=0 busy=0 alias=0", rs2_val, rs2_busy, rs2_alias);
    end
  endtask

  task automatic test_hold();
    rdy = 1'b0;
    rename_en = 1'b1; rename_rd = 5'd10; rename_alias = 4'd5;
    commit_en = 1'b1; commit_rd = 5'd11; commit_alias = 4'd0; commit_val = 32'hAB;
    step(); idle();
    rdy = 1'b1;
    rs1_idx = 5'd10; rs2_idx = 5'd11; #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_val !== 32'h0) begin
      failures++; $display("FAIL rdy_hold got busy10=%b val11=%h exp busy10=0 val11=0", rs1_busy, rs2_val);
    end
  endtask

  task automatic test_bypass();
    rename(5'd5, 4'd3);
    rs1_idx = 5'd5; rs2_idx = 5'd5;
    commit_en = 1'b1; commit_rd = 5'd5; commit_alias = 4'd3; commit_val = 32'h7;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rs1_busy !== 1'b0 || rs1_val !== 32'h7 || rs2_busy !== 1'b0 || rs2_alias !== 4'd0) begin
      failures++; $display("FAIL bypass_same got busy=%b/%b val=%h exp busy=0/0 val=7", rs1_busy, rs2_busy, rs1_val);
    end
`else
    checks++;
    if (rs1_busy !== 1'b1 || rs1_alias !== 4'd3 || rs2_busy !== 1'b1) begin
      failures++; $display("FAIL nobypass_same got busy=%b/%b alias=%0d exp busy=1/1 alias=3", rs1_busy, rs2_busy, rs1_alias);
    end
`endif
    step(); idle();
    checks++;
    if (rs1_busy !== 1'b0 || rs1_val !== 32'h7 || rs2_val !== 32'h7) begin
      failures++; $display("FAIL bypass_next got busy=%b val=%h/%h exp busy=0 val=7/7", rs1_busy, rs1_val, rs2_val);
    end
  endtask

  task automatic test_back_to_back();
    // Independent rename and commit on different registers in one cycle.
    rename(5'd12, 4'd1);
    commit_en = 1'b1; commit_rd = 5'd12; commit_alias = 4'd1; commit_val = 32'hC1;
    rename_en = 1'b1; rename_rd = 5'd13; rename_alias = 4'd2;
    step(); idle();
    rs1_idx = 5'd12; rs2_idx = 5'd13; #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs1_val !== 32'hC1 || rs2_busy !== 1'b1 || rs2_alias !== 4'd2) begin
      failures++; $display("FAIL back_to_back got x12 busy=%b val=%h x13 busy=%b alias=%0d exp 0/c1 1/2", rs1_busy, rs1_val, rs2_busy, rs2_alias);
    end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_younger_owner();
    test_same_cycle();
    test_rollback();
    test_x0();
    test_hold();
    test_bypass();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
